// File: rtl/multicycle_ctrl.sv
// Multi-cycle HI/LO sequencer: fixed-latency multiply path and 32-step restoring divider.
// Optional accumulate for MADD/MSUB is enabled by defining MULTICYCLE_MADD_EN.
module multicycle_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic [32:0] hi_wr,
  output logic [32:0] lo_wr
);

  localparam int unsigned XLEN      = 32;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned DIV_STEPS = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MSUB  = 3'd5
  } multicycle_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] data;
  } hilo_write_req_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                accept_c, finish_c;

  multicycle_t         op_in_c, op_q;
  logic                is_div_in_c;
  logic [XLEN-1:0]     a_q, b_q;
  logic [XLEN-1:0]     dq_q, dr_q;
  logic [XLEN-1:0]     hi_q, lo_q;
`ifdef MULTICYCLE_MADD_EN
  logic [2*XLEN-1:0]   acc_q;
`else
  logic                unused_acc_in;
  assign unused_acc_in = ^{hi_in, lo_in};
`endif

  logic [XLEN-1:0]     a_mag_in_c, b_mag_c;
  logic [XLEN:0]       rem_shift_c, rem_diff_c;
  logic [XLEN-1:0]     div_q_next_c, div_r_next_c;
  logic [2*XLEN-1:0]   prod_s_c, prod_u_c, mul_res_c;
  logic                neg_q_c, neg_r_c;
  logic [XLEN-1:0]     res_hi_c, res_lo_c;
  logic                wr_valid_c;
  hilo_write_req_t     hi_req_c, lo_req_c;

  assign op_in_c     = multicycle_t'(op);
  assign is_div_in_c = (op_in_c == OP_DIV) || (op_in_c == OP_DIVU);
  // Divider runs on magnitudes; the signed dividend is folded at accept time.
  assign a_mag_in_c  = ((op_in_c == OP_DIV) && a[XLEN-1]) ? -a : a;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid && !flush) begin
          accept_c = 1'b1;
          if (is_div_in_c) begin
            state_d = S_DIV;
            cnt_d   = CNT_W'(DIV_STEPS - 1);
          end else begin
            state_d = S_MUL;
            cnt_d   = CNT_W'(MUL_LAT - 1);
          end
        end
      end
      S_MUL, S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d  = S_DONE;
          finish_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One restoring step: borrow out of the 33-bit trial subtraction means "keep".
  always_comb begin
    b_mag_c      = ((op_q == OP_DIV) && b_q[XLEN-1]) ? -b_q : b_q;
    rem_shift_c  = {dr_q, dq_q[XLEN-1]};
    rem_diff_c   = rem_shift_c - {1'b0, b_mag_c};
    div_r_next_c = rem_shift_c[XLEN-1:0];
    div_q_next_c = {dq_q[XLEN-2:0], 1'b0};
    if (!rem_diff_c[XLEN]) begin
      div_r_next_c = rem_diff_c[XLEN-1:0];
      div_q_next_c = {dq_q[XLEN-2:0], 1'b1};
    end
  end

  always_comb begin
    prod_s_c = {{XLEN{a_q[XLEN-1]}}, a_q} * {{XLEN{b_q[XLEN-1]}}, b_q};
    prod_u_c = {{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q};
    case (op_q)
      OP_MULTU: mul_res_c = prod_u_c;
`ifdef MULTICYCLE_MADD_EN
      OP_MADD:  mul_res_c = acc_q + prod_s_c;
      OP_MSUB:  mul_res_c = acc_q - prod_s_c;
`endif
      default:  mul_res_c = prod_s_c;
    endcase
  end

  // Final result selection, including sign fix-up and divide-by-zero override.
  always_comb begin
    neg_q_c  = (op_q == OP_DIV) && (a_q[XLEN-1] ^ b_q[XLEN-1]);
    neg_r_c  = (op_q == OP_DIV) && a_q[XLEN-1];
    res_hi_c = '0;
    res_lo_c = '0;
    if (state_q == S_MUL) begin
      {res_hi_c, res_lo_c} = mul_res_c;
    end else if (b_q == '0) begin
      res_hi_c = a_q;
      res_lo_c = '1;
    end else begin
      res_lo_c = neg_q_c ? -div_q_next_c : div_q_next_c;
      res_hi_c = neg_r_c ? -div_r_next_c : div_r_next_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= OP_MULT;
      a_q   <= '0;
      b_q   <= '0;
      dq_q  <= '0;
      dr_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
`ifdef MULTICYCLE_MADD_EN
      acc_q <= '0;
`endif
    end else begin
      if (accept_c) begin
        op_q  <= op_in_c;
        a_q   <= a;
        b_q   <= b;
        dq_q  <= a_mag_in_c;
        dr_q  <= '0;
`ifdef MULTICYCLE_MADD_EN
        acc_q <= {hi_in, lo_in};
`endif
      end else if ((state_q == S_DIV) && !flush) begin
        dq_q <= div_q_next_c;
        dr_q <= div_r_next_c;
      end
      if (finish_c) begin
        hi_q <= res_hi_c;
        lo_q <= res_lo_c;
      end
    end
  end

  assign wr_valid_c = (state_q == S_DONE) && !flush;
  assign hi_req_c   = '{valid: wr_valid_c, data: hi_q};
  assign lo_req_c   = '{valid: wr_valid_c, data: lo_q};
  assign hi_wr      = hi_req_c;
  assign lo_wr      = lo_req_c;
  assign busy       = (state_q != S_IDLE);
  assign ready      = (state_q == S_IDLE) && !reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed + randomized bench for multicycle_ctrl against an arithmetic reference model.
module tb_multicycle_ctrl;

  localparam int unsigned MUL_LAT = 2;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;

  logic        clk = 1'b0;
  logic        reset, valid, flush;
  logic [2:0]  op;
  logic [31:0] a, b, hi_in, lo_in;
  logic        ready, busy, ready8, busy8;
  logic [32:0] hi_wr, lo_wr, hi_wr8, lo_wr8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .a(a), .b(b),
    .hi_in(hi_in), .lo_in(lo_in), .flush(flush),
    .ready(ready), .busy(busy), .hi_wr(hi_wr), .lo_wr(lo_wr)
  );

  multicycle_ctrl #(.MUL_LAT(8)) dut8 (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .a(a), .b(b),
    .hi_in(hi_in), .lo_in(lo_in), .flush(flush),
    .ready(ready8), .busy(busy8), .hi_wr(hi_wr8), .lo_wr(lo_wr8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {HI,LO} computed directly from the arithmetic definitions.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, y, h, l);
    longint      sx, sy, q, r;
    logic [63:0] ux, uy, uq, ur, ps;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    ps = 64'(sx * sy);
    case (o)
      OP_MULTU: return ux * uy;
      OP_DIV, OP_DIVU: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (o == OP_DIV) begin
          q = sx / sy;
          r = sx % sy;
          return {32'(r), 32'(q)};
        end
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
      end
`ifdef MULTICYCLE_MADD_EN
      OP_MADD: return {h, l} + ps;
      OP_MSUB: return {h, l} - ps;
`else
      OP_MADD: return ps + 64'(h & 32'd0) + 64'(l & 32'd0);
      OP_MSUB: return ps;
`endif
      default: return ps;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one request from an idle DUT and track write-valid, data, latency and busy.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, y, h, l,
                        input logic [31:0] exp_hi, exp_lo);
    int          exp_lat, got_lat, pulses, bad;
    logic [31:0] got_hi, got_lo;
    exp_lat = (o == OP_DIV || o == OP_DIVU) ? 33 : int'(MUL_LAT) + 1;
    got_lat = 0;
    pulses  = 0;
    bad     = 0;
    got_hi  = '0;
    got_lo  = '0;
    valid = 1'b1; op = o; a = x; b = y; hi_in = h; lo_in = l;
    @(negedge clk);
    check({tag, "_ready"}, 64'(ready), 64'd1);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom; hi_in = $urandom; lo_in = $urandom;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (hi_wr[32] === 1'b1) begin
        pulses++;
        got_lat = k;
        got_hi  = hi_wr[31:0];
        got_lo  = lo_wr[31:0];
      end
      if (lo_wr[32] !== hi_wr[32]) bad++;
      if (busy !== (k <= exp_lat)) bad++;
    end
    @(posedge clk); #1;
    check({tag, "_lat"}, 64'(got_lat), 64'(exp_lat));
    check({tag, "_pulses"}, 64'(pulses), 64'd1);
    check({tag, "_hi"}, 64'(got_hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(got_lo), 64'(exp_lo));
    check({tag, "_busy"}, 64'(bad), 64'd0);
  endtask

  initial begin
    logic [63:0] exp;
    logic [2:0]  ro;
    logic [31:0] ra, rb, rh, rl;
    int          wv;

    reset = 1'b1; valid = 1'b0; flush = 1'b0; op = OP_MULT;
    a = '0; b = '0; hi_in = '0; lo_in = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi_wr", 64'(hi_wr), 64'd0);
    check("rst_lo_wr", 64'(lo_wr), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_neg7", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'd0, 32'h8000_0000);
    run_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 0, 0, 32'd100, 32'hFFFF_FFFF);
    run_op("div_zero", OP_DIV, 32'hFFFF_FFF9, 32'd0, 0, 0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd10, 0, 0, 32'd5, 32'h1999_9999);
`ifdef MULTICYCLE_MADD_EN
    run_op("madd", OP_MADD, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    run_op("msub", OP_MSUB, 32'd1, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
    run_op("madd", OP_MADD, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd1);
    run_op("msub", OP_MSUB, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1);
`endif

    // Flush at cycle 10 of a divide; a new request is taken at cycle 11.
    wv = 0;
    valid = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    valid = 1'b0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      if (hi_wr[32] === 1'b1 || lo_wr[32] === 1'b1) wv++;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush_div_early_wr", 64'(wv), 64'd0);
    check("flush_div_wr", 64'({hi_wr[32], lo_wr[32]}), 64'd0);
    check("flush_div_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    run_op("after_flush", OP_MULT, 32'd6, 32'd7, 0, 0, 32'd0, 32'd42);

    // Flush landing on the completion cycle suppresses both writes.
    valid = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd3;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (MUL_LAT) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_done_busy", 64'(busy), 64'd1);
    check("flush_done_wr", 64'({hi_wr[32], lo_wr[32]}), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_done_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;

    // Flush in IDLE beats valid.
    valid = 1'b1; flush = 1'b1; op = OP_DIVU; a = 32'd5; b = 32'd1;
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idle_flush_noaccept", 64'(busy), 64'd0);
    @(posedge clk); #1;

    // Reset at cycle 5 of an 8-cycle multiply.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    valid = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd7;
    @(negedge clk);
    check("mid_rst_ready0", 64'(ready8), 64'd1);
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 64'(busy8), 64'd1);
    check("mid_rst_ready", 64'(ready8), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    wv = 0;
    for (int k = 6; k <= 13; k++) begin
      @(negedge clk);
      if (busy8 !== 1'b0 || ready8 !== 1'b1 || hi_wr8 !== 33'd0 || lo_wr8 !== 33'd0) wv++;
      @(posedge clk); #1;
    end
    check("mid_rst_outputs", 64'(wv), 64'd0);

    for (int i = 0; i < 40; i++) begin
      ro  = 3'($urandom_range(0, 5));
      ra  = pick();
      rb  = pick();
      rh  = $urandom;
      rl  = $urandom;
      exp = model(ro, ra, rb, rh, rl);
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, rh, rl, exp[63:32], exp[31:0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
